sensor_stream_packer: RTL and testbench
=======================================

Name: sensor_stream_packer

Overview:
- Capture-side counterpart of the pattern streamer. It packs narrow sensor readback samples into 256-bit words and writes them into a 256-bit-wide FIFO (wr_en/full) for block transfer back to the host.
- It is the writer end of the same wide-FIFO interface that the pattern path reads from with rd_en/empty/valid.
- It sits in the clk domain between the sensor sampling logic and the capture FIFO.

Parameters:
- SAMPLE_W, 32, width of one sensor sample.
- WORD_W, 256, FIFO word width; must be an integer multiple of SAMPLE_W.
- CNT_W, 32, width of the word and drop counters.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- capture_en  in  1  capture window; samples are accepted only while it is high.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_data  in  SAMPLE_W  sensor sample.
- fifo_full  in  1  capture FIFO full.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_din  out  WORD_W  FIFO write data.
- fill_level  out  clog2(LANES)+1  samples in the current partial word.
- word_count  out  CNT_W  words accepted by the FIFO.
- drop_count  out  CNT_W  completed words dropped.
- overflow  out  1  sticky; set on the first drop.
- busy  out  1  high when the state is not IDLE or a word is pending.

Behaviour:
- Lane count: LANES = WORD_W/SAMPLE_W (8 by default). The first sample of a word occupies bits [SAMPLE_W-1:0]; lane k occupies bits [k*SAMPLE_W +: SAMPLE_W].
- Reset: every output, the pack register, the output stage and the counters clear to 0; the state goes to IDLE. A reset mid-word discards the partial word and any pending word, with no write.
- States:
  - IDLE: go to FILL when capture_en=1.
  - FILL: each cycle with capture_en & sample_valid, write the lane and increment fill. When LANES samples are present, transfer the word to the output stage and set fill=0.
  - FLUSH: entered for one cycle when capture_en falls while fill>0. Zero-pad the unused lanes, transfer the word to the output stage, then go to IDLE.
  - If capture_en falls with fill=0, go directly to IDLE.
- Samples presented while capture_en=0 are ignored. A sample_valid in the same cycle capture_en falls is ignored.
- Output stage: a single register, out_word plus a pending flag.
  - fifo_wr_en = pending & ~fifo_full (combinational); fifo_din = out_word.
  - The write is accepted on that edge: pending clears and word_count increments.
- Latency: a word whose last sample arrives at edge N has pending=1 after N. fifo_wr_en is high in cycle N+1 if the FIFO is not full. Throughput is one word per LANES sample cycles, with no gaps required.
- Backpressure: if a word completes (or is flushed) while pending is still set and is not being written that cycle, the new word is dropped. drop_count increments and overflow sets.
  - Packing continues without stalling; the sensor side cannot be throttled.
- Simultaneous write and completion: if the pending word is written in the same cycle a new word completes, the new word takes the slot. No drop occurs.
- Counters wrap modulo 2^CNT_W. overflow clears only on reset.
- capture_en re-asserted during FLUSH: FLUSH completes, then IDLE goes to FILL on the next cycle.

Optional Feature:
- Macro: SENSOR_PACK_SEQ_TAG_EN.
- Defined: the top lane (bits [WORD_W-1:WORD_W-SAMPLE_W]) carries a SAMPLE_W-bit word sequence number. It starts at 0 after reset, increments per completed word, and includes dropped words, so the host can detect gaps. Samples per word = LANES-1, and fill_level saturates at LANES-1.
- Undefined: all LANES lanes carry samples and there is no sequence counter.

Decomposition:
- Package sensor_pack_pkg holds:
  - SAMPLE_W and WORD_W defaults and the LANES constant;
  - the state enum {IDLE, FILL, FLUSH};
  - a function for the samples-per-word count, which depends on SENSOR_PACK_SEQ_TAG_EN.
- One sub-module, pack_out_stage: the single-entry output register with pending flag, write/drop decision, word_count, drop_count and overflow.

Test Plan:
- Full word: capture_en=1, 8 samples 0x0..0x7 on consecutive cycles, fifo_full=0 -> one fifo_wr_en pulse in the cycle after sample 7; fifo_din=0x00000007_..._00000000; word_count=1.
- Partial flush: 3 samples 0xA,0xB,0xC, then capture_en=0 -> one write with lanes 0-2 = A,B,C and lanes 3-7 = 0; state returns to IDLE; fill_level=0.
- Backpressure drop: fifo_full=1 throughout 16 samples -> first word is held with wr_en=0; second word is dropped; drop_count=1, overflow=1. Deassert full -> the first word (0..7) is written and word_count=1.
- Simultaneous release: fifo_full deasserts in the same cycle the second word completes -> both words are written in consecutive cycles; drop_count=0.
- Reset mid-word: 5 samples then reset=1 for one cycle -> no write; all counters are 0; the next 8 samples yield a clean word starting at lane 0.
- SEQ_TAG (macro defined): 14 samples -> two words with lane 7 = 0 and 1 respectively and 7 samples each.

Source files
------------

// File: rtl/sensor_pack_pkg.sv
// sensor_pack_pkg: shared constants, state encoding and the samples-per-word
// helper for the sensor stream packer.
// Optional feature macro: SENSOR_PACK_SEQ_TAG_EN (top lane carries a word
// sequence number, so one lane fewer holds samples).
package sensor_pack_pkg;

    localparam int unsigned SAMPLE_W_DEF = 32;
    localparam int unsigned WORD_W_DEF   = 256;
    localparam int unsigned LANES        = WORD_W_DEF / SAMPLE_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } pack_state_e;

    // Number of lanes that carry sensor samples in one packed word.
    function automatic int unsigned samples_per_word(input int unsigned lanes);
`ifdef SENSOR_PACK_SEQ_TAG_EN
        return lanes - 1;
`else
        return lanes;
`endif
    endfunction

endpackage

// File: rtl/pack_out_stage.sv
// pack_out_stage: single-entry output register in front of the capture FIFO.
// Holds one completed word plus a pending flag, decides write vs. drop and
// keeps the accepted-word / dropped-word counters and the sticky overflow.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_word   a completed word is offered this cycle
//   fifo_full         capture FIFO full
//   fifo_wr_en        FIFO write strobe (pending & ~fifo_full)
//   fifo_din          FIFO write data
//   pending           a word is held in the output register
//   word_count        words accepted by the FIFO (wraps)
//   drop_count        completed words dropped (wraps)
//   overflow          sticky, set on the first drop
module pack_out_stage #(
    parameter int unsigned WORD_W = 256,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] push_word,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [WORD_W-1:0] fifo_din,
    output logic              pending,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow
);

    logic [WORD_W-1:0] word_q;
    logic              pending_q;
    logic [CNT_W-1:0]  word_count_q;
    logic [CNT_W-1:0]  drop_count_q;
    logic              overflow_q;

    assign fifo_wr_en = pending_q & ~fifo_full;
    assign fifo_din   = word_q;
    assign pending    = pending_q;
    assign word_count = word_count_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q       <= '0;
            pending_q    <= 1'b0;
            word_count_q <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (fifo_wr_en) begin
                word_count_q <= word_count_q + 1'b1;
            end
            if (push) begin
                // The slot frees up if the held word leaves on this same edge.
                if (pending_q && !fifo_wr_en) begin
                    drop_count_q <= drop_count_q + 1'b1;
                    overflow_q   <= 1'b1;
                end else begin
                    word_q    <= push_word;
                    pending_q <= 1'b1;
                end
            end else if (fifo_wr_en) begin
                pending_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sensor_stream_packer.sv
// sensor_stream_packer: packs SAMPLE_W-bit sensor samples into WORD_W-bit
// words (lane 0 first) and writes them into the capture FIFO.
// Optional feature macro: SENSOR_PACK_SEQ_TAG_EN -- top lane holds a word
// sequence number (counts dropped words too); LANES-1 samples per word.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   capture_en            capture window
//   sample_valid          sample_data valid this cycle
//   sample_data           sensor sample
//   fifo_full             capture FIFO full
//   fifo_wr_en, fifo_din  FIFO write strobe and data
//   fill_level            samples in the current partial word
//   word_count            words accepted by the FIFO
//   drop_count            completed words dropped
//   overflow              sticky drop indicator
//   busy                  state not IDLE or a word pending
module sensor_stream_packer
    import sensor_pack_pkg::*;
#(
    parameter int unsigned  SAMPLE_W = SAMPLE_W_DEF,
    parameter int unsigned  WORD_W   = WORD_W_DEF,
    parameter int unsigned  CNT_W    = 32,
    localparam int unsigned FILL_W   = $clog2(WORD_W / SAMPLE_W) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                capture_en,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                fifo_full,
    output logic                fifo_wr_en,
    output logic [WORD_W-1:0]   fifo_din,
    output logic [FILL_W-1:0]   fill_level,
    output logic [CNT_W-1:0]    word_count,
    output logic [CNT_W-1:0]    drop_count,
    output logic                overflow,
    output logic                busy
);

    localparam int unsigned       NUM_LANES = WORD_W / SAMPLE_W;
    localparam int unsigned       SPW       = samples_per_word(NUM_LANES);
    localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(SPW - 1);

    pack_state_e       state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [WORD_W-1:0] assembled;
    logic [WORD_W-1:0] word_base;
    logic [WORD_W-1:0] push_word;
    logic              push;
    logic              pending;

    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        pack_d    = pack_q;
        push      = 1'b0;
        assembled = pack_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (FILL_W'(k) == fill_q) begin
                assembled[k*SAMPLE_W +: SAMPLE_W] = sample_data;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (capture_en) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                // A sample arriving as capture_en falls is ignored.
                if (!capture_en) begin
                    state_d = (fill_q != '0) ? FLUSH : IDLE;
                end else if (sample_valid) begin
                    if (fill_q == LAST_FILL) begin
                        push   = 1'b1;
                        fill_d = '0;
                        pack_d = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                        pack_d = assembled;
                    end
                end
            end
            FLUSH: begin
                // Unused lanes are already zero: pack_q is cleared per word.
                push    = 1'b1;
                fill_d  = '0;
                pack_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        word_base = (state_q == FLUSH) ? pack_q : assembled;
    end

`ifdef SENSOR_PACK_SEQ_TAG_EN
    logic [SAMPLE_W-1:0] seq_q;

    always_comb begin
        push_word = word_base;
        push_word[WORD_W-1 -: SAMPLE_W] = seq_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_q <= '0;
        end else if (push) begin
            seq_q <= seq_q + 1'b1;
        end
    end
`else
    assign push_word = word_base;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fill_q  <= '0;
            pack_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            pack_q  <= pack_d;
        end
    end

    pack_out_stage #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_out_stage (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_word  (push_word),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .pending    (pending),
        .word_count (word_count),
        .drop_count (drop_count),
        .overflow   (overflow)
    );

    assign fill_level = fill_q;
    assign busy       = (state_q != IDLE) | pending;

endmodule

// File: tb/tb_sensor_stream_packer.sv
// Directed bench for sensor_stream_packer (default 32-bit samples, 256-bit words).
module tb_sensor_stream_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic         capture_en;
    logic         sample_valid;
    logic [31:0]  sample_data;
    logic         fifo_full;
    logic         fifo_wr_en;
    logic [255:0] fifo_din;
    logic [3:0]   fill_level;
    logic [31:0]  word_count;
    logic [31:0]  drop_count;
    logic         overflow;
    logic         busy;

    int total = 0;
    int bad = 0;
    int wr_seen = 0;

    sensor_stream_packer dut (
        .clk          (clk),
        .reset        (reset),
        .capture_en   (capture_en),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_din     (fifo_din),
        .fill_level   (fill_level),
        .word_count   (word_count),
        .drop_count   (drop_count),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) wr_seen++;
    end

    // Word with lanes 0..n-1 = base+k and the remaining lanes zero.
    function automatic logic [255:0] mk(input logic [31:0] base, input int n);
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[k*32 +: 32] = base + 32'(k);
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; capture_en = 1'b0; sample_valid = 1'b0;
        sample_data = '0; fifo_full = 1'b0;
        step();
        reset = 1'b0;
        wr_seen = 0;
    endtask

    task automatic send(input logic [31:0] d);
        sample_valid = 1'b1; sample_data = d;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); end
        total++; if (fill_level !== 4'd0) begin bad++; $display("FAIL reset_fill got %0d want 0", fill_level); end
        total++; if (word_count !== 32'd0) begin bad++; $display("FAIL reset_words got %0d want 0", word_count); end
        total++; if (drop_count !== 32'd0) begin bad++; $display("FAIL reset_drops got %0d want 0", drop_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (fifo_din !== 256'd0) begin bad++; $display("FAIL reset_din got %h want 0", fifo_din); end
    endtask

`ifndef SENSOR_PACK_SEQ_TAG_EN
    task automatic test_full_word();
        do_reset();
        capture_en = 1'b1;
        step();
        for (int i = 0; i < 8; i++) send(32'(i));
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL full_wr_en got %b want 1", fifo_wr_en); end
        total++; if (fifo_din !== mk(32'h0, 8)) begin bad++; $display("FAIL full_din got %h want %h", fifo_din, mk(32'h0, 8)); end
        step();
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL full_wr_after got %b want 0", fifo_wr_en); end
        total++; if (word_count !== 32'd1) begin bad++; $display("FAIL full_words got %0d want 1", word_count); end
        total++; if (wr_seen !== 1) begin bad++; $display("FAIL full_pulses got %0d want 1", wr_seen); end
        total++; if (fill_level !== 4'd0) begin bad++; $display("FAIL full_fill got %0d want 0", fill_level); end
        capture_en = 1'b0;
        step();
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_partial_flush();
        logic [255:0] exp;
        exp = '0;
        exp[31:0] = 32'hA; exp[63:32] = 32'hB; exp[95:64] = 32'hC;
        do_reset();
        capture_en = 1'b1;
        step();
        send(32'hA); send(32'hB); send(32'hC);
        @(negedge clk);
        total++; if (fill_level !== 4'd3) begin bad++; $display("FAIL flush_fill3 got %0d want 3", fill_level); end
        capture_en = 1'b0;
        step();
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy got %b want 1", busy); end
        total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL flush_early_wr got %b want 0", fifo_wr_en); end
        step();
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL flush_wr_en got %b want 1", fifo_wr_en); end
        total++; if (fifo_din !== exp) begin bad++; $display("FAIL flush_din got %h want %h", fifo_din, exp); end
        step();
        @(negedge clk);
        total++; if (word_count !== 32'd1) begin bad++; $display("FAIL flush_words got %0d want 1", word_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle got %b want 0", busy); end
        total++; if (fill_level !== 4'd0) begin bad++; $display("FAIL flush_fill0 got %0d want 0", fill_level); end
        total++; if (wr_seen !== 1) begin bad++; $display("FAIL flush_pulses got %0d want 1", wr_seen); end
    endtask

    task automatic test_backpressure();
        do_reset();
        fifo_full = 1'b1;
        capture_en = 1'b1;
        step();
        for (int i = 0; i < 16; i++) send(32'(i));
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL bp_wr_en got %b want 0", fifo_wr_en); end
        total++; if (drop_count !== 32'd1) begin bad++; $display("FAIL bp_drops got %0d want 1", drop_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow got %b want 1", overflow); end
        total++; if (word_count !== 32'd0) begin bad++; $display("FAIL bp_words0 got %0d want 0", word_count); end
        fifo_full = 1'b0;
        #1;
        total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL bp_release got %b want 1", fifo_wr_en); end
        total++; if (fifo_din !== mk(32'h0, 8)) begin bad++; $display("FAIL bp_din got %h want %h", fifo_din, mk(32'h0, 8)); end
        step();
        @(negedge clk);
        total++; if (word_count !== 32'd1) begin bad++; $display("FAIL bp_words1 got %0d want 1", word_count); end
        total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL bp_wr_after got %b want 0", fifo_wr_en); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_sticky got %b want 1", overflow); end
        capture_en = 1'b0;
        step();
    endtask

    task automatic test_simultaneous();
        do_reset();
        fifo_full = 1'b1;
        capture_en = 1'b1;
        step();
        for (int i = 0; i < 15; i++) send(32'(i));
        fifo_full = 1'b0;
        sample_valid = 1'b1; sample_data = 32'd15;
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL sim_wr1 got %b want 1", fifo_wr_en); end
        total++; if (fifo_din !== mk(32'h0, 8)) begin bad++; $display("FAIL sim_din1 got %h want %h", fifo_din, mk(32'h0, 8)); end
        step();
        sample_valid = 1'b0;
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL sim_wr2 got %b want 1", fifo_wr_en); end
        total++; if (fifo_din !== mk(32'h8, 8)) begin bad++; $display("FAIL sim_din2 got %h want %h", fifo_din, mk(32'h8, 8)); end
        step();
        @(negedge clk);
        total++; if (word_count !== 32'd2) begin bad++; $display("FAIL sim_words got %0d want 2", word_count); end
        total++; if (drop_count !== 32'd0) begin bad++; $display("FAIL sim_drops got %0d want 0", drop_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sim_overflow got %b want 0", overflow); end
        capture_en = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        capture_en = 1'b1;
        step();
        for (int i = 0; i < 5; i++) send(32'hDEAD_0000 + 32'(i));
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        total++; if (fill_level !== 4'd0) begin bad++; $display("FAIL mid_fill got %0d want 0", fill_level); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got %b want 0", busy); end
        total++; if (word_count !== 32'd0) begin bad++; $display("FAIL mid_words got %0d want 0", word_count); end
        total++; if (wr_seen !== 0) begin bad++; $display("FAIL mid_no_write got %0d want 0", wr_seen); end
        step();
        for (int i = 0; i < 8; i++) send(32'h100 + 32'(i));
        @(negedge clk);
        total++; if (fifo_din !== mk(32'h100, 8)) begin bad++; $display("FAIL mid_clean_din got %h want %h", fifo_din, mk(32'h100, 8)); end
        step();
        @(negedge clk);
        total++; if (word_count !== 32'd1) begin bad++; $display("FAIL mid_clean_words got %0d want 1", word_count); end
        total++; if (wr_seen !== 1) begin bad++; $display("FAIL mid_clean_pulses got %0d want 1", wr_seen); end
        capture_en = 1'b0;
        step();
    endtask
`else
    task automatic test_seq_tag();
        logic [255:0] exp0;
        logic [255:0] exp1;
        exp0 = mk(32'h20, 7);
        exp1 = mk(32'h27, 7);
        exp1[255:224] = 32'd1;
        do_reset();
        capture_en = 1'b1;
        step();
        for (int i = 0; i < 7; i++) send(32'h20 + 32'(i));
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL seq_wr0 got %b want 1", fifo_wr_en); end
        total++; if (fifo_din !== exp0) begin bad++; $display("FAIL seq_din0 got %h want %h", fifo_din, exp0); end
        total++; if (fill_level !== 4'd0) begin bad++; $display("FAIL seq_fill got %0d want 0", fill_level); end
        for (int i = 7; i < 14; i++) send(32'h20 + 32'(i));
        @(negedge clk);
        total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL seq_wr1 got %b want 1", fifo_wr_en); end
        total++; if (fifo_din !== exp1) begin bad++; $display("FAIL seq_din1 got %h want %h", fifo_din, exp1); end
        step();
        @(negedge clk);
        total++; if (word_count !== 32'd2) begin bad++; $display("FAIL seq_words got %0d want 2", word_count); end
        capture_en = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
`ifndef SENSOR_PACK_SEQ_TAG_EN
        test_full_word();
        test_partial_flush();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_word();
`else
        test_seq_tag();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
